// File: rtl/control_pkg.sv
// Shared encodings for the RV32I multicycle controller: FSM states, opcodes,
// datapath mux selects and ALU operations (the ALU uses the same op codes).
package control_pkg;

  // JAL/JALR and LUI/AUIPC each share one state; op_code picks the operand
  // selects, which keeps the encoding within 4 bits.
  typedef enum logic [3:0] {
    S_FETCH, S_FETCH_WAIT, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WAIT,
    S_MEM_WB, S_MEM_WRITE, S_EXEC_R, S_EXEC_I, S_UPPER, S_ALU_WB,
    S_BRANCH, S_JUMP_CALC, S_JUMP, S_LINK
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] RES_ALU    = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_PC4    = 2'd2;
  localparam logic [1:0] RES_OLDPC4 = 2'd3;

  localparam logic [1:0] A_PC    = 2'd0;
  localparam logic [1:0] A_OLDPC = 2'd1;
  localparam logic [1:0] A_RS1   = 2'd2;
  localparam logic [1:0] A_ZERO  = 2'd3;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7[5] to an ALU op for R-type and I-type ALU instructions.
module alu_decoder
  import control_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       f7b5,
  input  logic       is_r,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      3'b000:  alu_control = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_control = ALU_SLL;
      3'b010:  alu_control = ALU_SLT;
      3'b011:  alu_control = ALU_SLTU;
      3'b100:  alu_control = ALU_XOR;
      // srai carries f7b5 in its immediate, so it applies to both forms
      3'b101:  alu_control = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_control = ALU_OR;
      default: alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RV32I main controller: sequences fetch/decode/execute/memory/
// writeback and drives every datapath enable and mux select.
module control_fsm
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_code,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       ALUResultLSB,
  output logic       adr_src,
  output logic       mem_write,
  output logic       IR_write,
  output logic       reg_write,
  output logic       PC_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       instr_retired,
  output logic       illegal_instr
);

  state_t     state, next_state;
  logic [3:0] dec_alu;
  logic       is_store;
  logic       unused_f7;

  assign unused_f7 = ^{funct7[6], funct7[4:0]};
  assign is_store  = (op_code == OP_STORE);

  alu_decoder u_dec (
    .funct3      (funct3),
    .f7b5        (funct7[5]),
    .is_r        (state == S_EXEC_R),
    .alu_control (dec_alu)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    IR_write      = 1'b0;
    reg_write     = 1'b0;
    PC_write      = 1'b0;
    result_src    = RES_ALU;
    alu_src_a     = A_PC;
    alu_src_b     = B_RS2;
    imm_src       = IMM_I;
    alu_control   = ALU_ADD;
    instr_retired = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: next_state = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        IR_write   = 1'b1;
        PC_write   = 1'b1;
        result_src = RES_PC4;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        // ALU_out captures the branch target for a following BRANCH state
        alu_src_a  = A_OLDPC;
        alu_src_b  = B_IMM;
        imm_src    = IMM_B;
        next_state = S_FETCH;
        case (op_code)
          OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
          OP_R:              next_state = S_EXEC_R;
          OP_I:              next_state = S_EXEC_I;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL, OP_JALR:   next_state = S_JUMP_CALC;
          OP_LUI, OP_AUIPC:  next_state = S_UPPER;
          OP_FENCE:          instr_retired = 1'b1;
          default:           illegal_instr = 1'b1;
        endcase
      end
      S_MEM_ADR, S_MEM_READ, S_MEM_WAIT, S_MEM_WRITE: begin
        // address calc is held across the access so ALU_out stays stable
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        imm_src   = is_store ? IMM_S : IMM_I;
        case (state)
          S_MEM_ADR:  next_state = is_store ? S_MEM_WRITE : S_MEM_READ;
          S_MEM_READ: begin adr_src = 1'b1; next_state = S_MEM_WAIT; end
          S_MEM_WAIT: begin adr_src = 1'b1; next_state = S_MEM_WB;   end
          default: begin
            adr_src       = 1'b1;
            mem_write     = 1'b1;
            instr_retired = 1'b1;
            next_state    = S_FETCH;
          end
        endcase
      end
      S_MEM_WB: begin
        result_src    = RES_MEM;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a   = A_RS1;
        alu_src_b   = B_RS2;
        alu_control = dec_alu;
        next_state  = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a   = A_RS1;
        alu_src_b   = B_IMM;
        imm_src     = IMM_I;
        alu_control = dec_alu;
        next_state  = S_ALU_WB;
      end
      S_UPPER: begin
        alu_src_a  = (op_code == OP_LUI) ? A_ZERO : A_OLDPC;
        alu_src_b  = B_IMM;
        imm_src    = IMM_U;
        next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = A_RS1;
        alu_src_b     = B_RS2;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
        case (funct3[2:1])
          2'b10:   alu_control = ALU_SLT;
          2'b11:   alu_control = ALU_SLTU;
          default: alu_control = ALU_SUB;
        endcase
        case (funct3)
          3'b000:         PC_write = Zero;
          3'b001:         PC_write = !Zero;
          3'b100, 3'b110: PC_write = ALUResultLSB;
          3'b101, 3'b111: PC_write = !ALUResultLSB;
          default:        PC_write = 1'b0;
        endcase
      end
      S_JUMP_CALC: begin
        alu_src_b  = B_IMM;
        alu_src_a  = (op_code == OP_JALR) ? A_RS1 : A_OLDPC;
        imm_src    = (op_code == OP_JALR) ? IMM_I : IMM_J;
        next_state = S_JUMP;
      end
      S_JUMP: begin
        PC_write   = 1'b1;
        next_state = S_LINK;
      end
      S_LINK: begin
        result_src    = RES_OLDPC4;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: per-cycle expected control vectors are
// queued per instruction and compared as the FSM steps through it.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op_code;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero, ALUResultLSB;
  logic       adr_src, mem_write, IR_write, reg_write, PC_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       instr_retired, illegal_instr;

  logic [19:0] outs;
  logic [19:0] sb[$];
  int n_cmp = 0;
  int n_mis = 0;

  control_fsm dut (
    .clk(clk), .reset(reset), .op_code(op_code), .funct3(funct3),
    .funct7(funct7), .Zero(Zero), .ALUResultLSB(ALUResultLSB),
    .adr_src(adr_src), .mem_write(mem_write), .IR_write(IR_write),
    .reg_write(reg_write), .PC_write(PC_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .instr_retired(instr_retired),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  assign outs = {adr_src, mem_write, IR_write, reg_write, PC_write, result_src,
                 alu_src_a, alu_src_b, imm_src, alu_control, instr_retired,
                 illegal_instr};

  function automatic logic [19:0] v(input logic adr, mw, irw, rw, pcw,
                                    input logic [1:0] rs, sa, sbs,
                                    input logic [2:0] imm, input logic [3:0] alu,
                                    input logic ret, ill);
    return {adr, mw, irw, rw, pcw, rs, sa, sbs, imm, alu, ret, ill};
  endfunction

  // Reference cycle-by-cycle sequence per instruction class.
  task automatic push_instr(input logic [6:0] op, input logic [3:0] alu_exp,
                            input logic pcw_exp);
    sb.push_back(20'h0);
    sb.push_back(v(0,0,1,0,1, 2'd2, 2'd0, 2'd0, 3'd0, 4'd0, 0,0));
    case (op)
      7'b0001111: sb.push_back(v(0,0,0,0,0, 0, 1, 1, 3'd2, 0, 1,0));
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111:
                  sb.push_back(v(0,0,0,0,0, 0, 1, 1, 3'd2, 0, 0,0));
      default:    sb.push_back(v(0,0,0,0,0, 0, 1, 1, 3'd2, 0, 0,1));
    endcase
    case (op)
      7'b0000011: begin
        sb.push_back(v(0,0,0,0,0, 0, 2, 1, 3'd0, 0, 0,0));
        sb.push_back(v(1,0,0,0,0, 0, 2, 1, 3'd0, 0, 0,0));
        sb.push_back(v(1,0,0,0,0, 0, 2, 1, 3'd0, 0, 0,0));
        sb.push_back(v(0,0,0,1,0, 1, 0, 0, 3'd0, 0, 1,0));
      end
      7'b0100011: begin
        sb.push_back(v(0,0,0,0,0, 0, 2, 1, 3'd1, 0, 0,0));
        sb.push_back(v(1,1,0,0,0, 0, 2, 1, 3'd1, 0, 1,0));
      end
      7'b0110011: begin
        sb.push_back(v(0,0,0,0,0, 0, 2, 0, 3'd0, alu_exp, 0,0));
        sb.push_back(v(0,0,0,1,0, 0, 0, 0, 3'd0, 0, 1,0));
      end
      7'b0010011: begin
        sb.push_back(v(0,0,0,0,0, 0, 2, 1, 3'd0, alu_exp, 0,0));
        sb.push_back(v(0,0,0,1,0, 0, 0, 0, 3'd0, 0, 1,0));
      end
      7'b0110111, 7'b0010111: begin
        sb.push_back(v(0,0,0,0,0, 0, (op == 7'b0110111) ? 2'd3 : 2'd1, 1,
                       3'd3, 0, 0,0));
        sb.push_back(v(0,0,0,1,0, 0, 0, 0, 3'd0, 0, 1,0));
      end
      7'b1100011:
        sb.push_back(v(0,0,0,0,pcw_exp, 0, 2, 0, 3'd0, alu_exp, 1,0));
      7'b1101111, 7'b1100111: begin
        if (op == 7'b1100111) sb.push_back(v(0,0,0,0,0, 0, 2, 1, 3'd0, 0, 0,0));
        else                  sb.push_back(v(0,0,0,0,0, 0, 1, 1, 3'd4, 0, 0,0));
        sb.push_back(v(0,0,0,0,1, 0, 0, 0, 3'd0, 0, 0,0));
        sb.push_back(v(0,0,0,1,0, 3, 0, 0, 3'd0, 0, 1,0));
      end
      default: ;
    endcase
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic z, input logic l);
    op_code = op; funct3 = f3; funct7 = f7; Zero = z; ALUResultLSB = l;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if (outs !== 20'h0) begin
        n_mis++;
        $display("FAIL reset_hold[%0d]: got %h want %h", k, outs, 20'h0);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    // start a load, then abort it with reset while in the memory read state
    drive(7'b0000011, 3'b010, 7'h00, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (outs !== 20'h0) begin
        n_mis++;
        $display("FAIL reset_midload[%0d]: got %h want %h", k, outs, 20'h0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_alu();
    logic [6:0] ops[16] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                            7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                            7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011,
                            7'b0010011, 7'b0010011, 7'b0110111, 7'b0010111};
    logic [2:0] f3s[16] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7, 0, 5, 5, 2, 3, 6};
    logic [6:0] f7s[16] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
                            7'h20, 7'h00, 7'h00, 7'h20, 7'h20, 7'h00, 7'h00,
                            7'h20, 7'h20};
    logic [3:0] alus[16] = '{0, 1, 5, 8, 9, 4, 6, 7, 3, 2, 0, 7, 6, 8, 0, 0};
    for (int i = 0; i < 16; i++) begin
      drive(ops[i], f3s[i], f7s[i], 1'b1, 1'b1);
      push_instr(ops[i], alus[i], 1'b0);
      for (int c = 0; sb.size() != 0; c++) begin
        logic [19:0] exp;
        #1;
        exp = sb.pop_front();
        n_cmp++;
        if (outs !== exp) begin
          n_mis++;
          $display("FAIL alu[%0d] cyc%0d: got %h want %h", i, c, outs, exp);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_mem();
    logic [6:0] ops[3] = '{7'b0000011, 7'b0100011, 7'b0000011};
    logic [2:0] f3s[3] = '{3'b010, 3'b010, 3'b000};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], f3s[i], 7'h20, 1'b0, 1'b1);
      push_instr(ops[i], 4'd0, 1'b0);
      for (int c = 0; sb.size() != 0; c++) begin
        logic [19:0] exp;
        #1;
        exp = sb.pop_front();
        n_cmp++;
        if (outs !== exp) begin
          n_mis++;
          $display("FAIL mem[%0d] cyc%0d: got %h want %h", i, c, outs, exp);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s[10] = '{0, 0, 1, 1, 4, 4, 5, 5, 6, 7};
    logic       zs[10]  = '{1, 0, 0, 1, 0, 1, 0, 1, 1, 1};
    logic       ls[10]  = '{0, 1, 1, 0, 1, 0, 1, 0, 1, 0};
    logic [3:0] alus[10] = '{1, 1, 1, 1, 8, 8, 8, 8, 9, 9};
    logic       tk[10]  = '{1, 0, 1, 0, 1, 0, 0, 1, 1, 1};
    for (int i = 0; i < 10; i++) begin
      drive(7'b1100011, f3s[i], 7'h00, zs[i], ls[i]);
      push_instr(7'b1100011, alus[i], tk[i]);
      for (int c = 0; sb.size() != 0; c++) begin
        logic [19:0] exp;
        #1;
        exp = sb.pop_front();
        n_cmp++;
        if (outs !== exp) begin
          n_mis++;
          $display("FAIL branch[%0d] cyc%0d: got %h want %h", i, c, outs, exp);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_jump_misc();
    logic [6:0] ops[5] = '{7'b1100111, 7'b1101111, 7'b1111111, 7'b0001111,
                           7'b0000000};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], 3'b000, 7'h00, 1'b1, 1'b1);
      push_instr(ops[i], 4'd0, 1'b0);
      for (int c = 0; sb.size() != 0; c++) begin
        logic [19:0] exp;
        #1;
        exp = sb.pop_front();
        n_cmp++;
        if (outs !== exp) begin
          n_mis++;
          $display("FAIL jump_misc[%0d] cyc%0d: got %h want %h", i, c, outs, exp);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(7'h00, 3'h0, 7'h00, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_jump_misc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
